// File: rtl/id_stage_fwd_pkg.sv
// Decode constants and small helpers shared by the flowCPU ID stage.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    typedef enum logic [7:0] {
        ALUOP_NOP  = 8'h00,
        ALUOP_SRL  = 8'h02,
        ALUOP_SRA  = 8'h03,
        ALUOP_ADDU = 8'h21,
        ALUOP_SUBU = 8'h23,
        ALUOP_AND  = 8'h24,
        ALUOP_OR   = 8'h25,
        ALUOP_XOR  = 8'h26,
        ALUOP_NOR  = 8'h27,
        ALUOP_SLL  = 8'h7C
    } aluop_e;

    typedef enum logic [2:0] {
        ALUSEL_NOP   = 3'd0,
        ALUSEL_LOGIC = 3'd1,
        ALUSEL_SHIFT = 3'd2,
        ALUSEL_ARITH = 3'd4
    } alusel_e;

    typedef struct packed {
        aluop_e  aluop;
        alusel_e alusel;
        logic    shift;   // operand 1 comes from the sa field instead of rs
        logic    ok;
    } special_t;

    function automatic special_t decode_special(input logic [5:0] funct);
        special_t s;
        s.aluop  = ALUOP_NOP;
        s.alusel = ALUSEL_NOP;
        s.shift  = 1'b0;
        s.ok     = 1'b1;
        case (funct)
            F_AND:  begin s.aluop = ALUOP_AND;  s.alusel = ALUSEL_LOGIC; end
            F_OR:   begin s.aluop = ALUOP_OR;   s.alusel = ALUSEL_LOGIC; end
            F_XOR:  begin s.aluop = ALUOP_XOR;  s.alusel = ALUSEL_LOGIC; end
            F_NOR:  begin s.aluop = ALUOP_NOR;  s.alusel = ALUSEL_LOGIC; end
            F_ADDU: begin s.aluop = ALUOP_ADDU; s.alusel = ALUSEL_ARITH; end
            F_SUBU: begin s.aluop = ALUOP_SUBU; s.alusel = ALUSEL_ARITH; end
            F_SLL:  begin s.aluop = ALUOP_SLL;  s.alusel = ALUSEL_SHIFT; s.shift = 1'b1; end
            F_SRL:  begin s.aluop = ALUOP_SRL;  s.alusel = ALUSEL_SHIFT; s.shift = 1'b1; end
            F_SRA:  begin s.aluop = ALUOP_SRA;  s.alusel = ALUSEL_SHIFT; s.shift = 1'b1; end
            default: s.ok = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/id_operand_mux.sv
// One ID operand: immediate when the read is disabled, else $0 / EX / MEM / regfile in that priority.
module id_operand_mux #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               re_i,
    input  logic [RADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [DATA_W-1:0]  rf_rdata_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    output logic [DATA_W-1:0]  opnd_o
);

    always_comb begin
        opnd_o = rf_rdata_i;
        if (!re_i)
            opnd_o = imm_i;
        else if (raddr_i == '0)
            opnd_o = '0;
        else if (ex_wreg_i && ex_wd_i == raddr_i)
            opnd_o = ex_wdata_i;
        else if (mem_wreg_i && mem_wd_i == raddr_i)
            opnd_o = mem_wdata_i;
    end

endmodule

// File: rtl/id_stage_fwd.sv
// flowCPU decode stage: MIPS32 decode, EX/MEM forwarding, load-use stall, registered ID/EX bundle.
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [31:0]         inst_i,
    output logic                rf_re1,
    output logic                rf_re2,
    output logic [RADDR_W-1:0]  rf_raddr1,
    output logic [RADDR_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]   rf_rdata1,
    input  logic [DATA_W-1:0]   rf_rdata2,
    input  logic                ex_wreg,
    input  logic [RADDR_W-1:0]  ex_wd,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_is_load,
    input  logic                mem_wreg,
    input  logic [RADDR_W-1:0]  mem_wd,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [DATA_W-1:0]   reg1_o,
    output logic [DATA_W-1:0]   reg2_o,
    output logic [RADDR_W-1:0]  wd_o,
    output logic                wreg_o,
    output logic                inst_invalid_o
);

    logic [5:0]         op, funct;
    logic [RADDR_W-1:0] rs, rt, rd;
    logic [4:0]         sa;
    logic [15:0]        imm;
    special_t           sp;

    assign op    = inst_i[31:26];
    assign rs    = RADDR_W'(inst_i[25:21]);
    assign rt    = RADDR_W'(inst_i[20:16]);
    assign rd    = RADDR_W'(inst_i[15:11]);
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm   = inst_i[15:0];
    assign sp    = decode_special(funct);

    logic               re1, re2, wreg_d, invalid_d;
    logic [DATA_W-1:0]  imm1, imm2;
    logic [RADDR_W-1:0] wd_d;
    aluop_e             aluop_d;
    alusel_e            alusel_d;

    always_comb begin
        re1       = 1'b0;
        re2       = 1'b0;
        imm1      = '0;
        imm2      = '0;
        wd_d      = '0;
        wreg_d    = 1'b0;
        aluop_d   = ALUOP_NOP;
        alusel_d  = ALUSEL_NOP;
        invalid_d = 1'b1;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                re1       = 1'b1;
                imm2      = DATA_W'(imm);
                wd_d      = rt;
                wreg_d    = 1'b1;
                alusel_d  = ALUSEL_LOGIC;
                invalid_d = 1'b0;
                aluop_d   = (op == OP_ORI)  ? ALUOP_OR :
                            (op == OP_ANDI) ? ALUOP_AND : ALUOP_XOR;
            end
            OP_LUI: begin
                imm2      = DATA_W'({imm, 16'h0000});
                wd_d      = rt;
                wreg_d    = 1'b1;
                aluop_d   = ALUOP_OR;
                alusel_d  = ALUSEL_LOGIC;
                invalid_d = 1'b0;
            end
            OP_SPECIAL: begin
                if (sp.ok) begin
                    re1       = !sp.shift;
                    re2       = 1'b1;
                    imm1      = DATA_W'(sa);
                    wd_d      = rd;
                    wreg_d    = 1'b1;
                    aluop_d   = sp.aluop;
                    alusel_d  = sp.alusel;
                    invalid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign rf_re1    = re1;
    assign rf_re2    = re2;
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    logic [DATA_W-1:0] opnd1, opnd2;

    id_operand_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_opnd1 (
        .re_i(re1), .raddr_i(rs), .imm_i(imm1), .rf_rdata_i(rf_rdata1),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .opnd_o(opnd1)
    );

    id_operand_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_opnd2 (
        .re_i(re2), .raddr_i(rt), .imm_i(imm2), .rf_rdata_i(rf_rdata2),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .opnd_o(opnd2)
    );

    // A load in EX has no data yet; wait one cycle so MEM forwarding picks it up.
    logic stall, advance;
    assign stall   = ex_is_load && ex_wreg && (ex_wd != '0) &&
                     ((re1 && ex_wd == rs) || (re2 && ex_wd == rt));
    assign advance = out_ready || !out_valid;
    assign in_ready = flush || (advance && !stall);

    logic                valid_q, wreg_q, invalid_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ALUOP_W-1:0]  aluop_q;
    logic [ALUSEL_W-1:0] alusel_q;
    logic [DATA_W-1:0]   reg1_q, reg2_q;
    logic [RADDR_W-1:0]  wd_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            aluop_q   <= '0;
            alusel_q  <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else if (advance && stall) begin
            valid_q <= 1'b0;
        end else if (advance && in_valid) begin
            valid_q   <= 1'b1;
            pc_q      <= pc_i;
            aluop_q   <= ALUOP_W'(aluop_d);
            alusel_q  <= ALUSEL_W'(alusel_d);
            reg1_q    <= opnd1;
            reg2_q    <= opnd2;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            invalid_q <= invalid_d;
        end else if (advance) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign pc_o           = pc_q;
    assign aluop_o        = aluop_q;
    assign alusel_o       = alusel_q;
    assign reg1_o         = reg1_q;
    assign reg2_o         = reg2_q;
    assign wd_o           = wd_q;
    assign wreg_o         = wreg_q;
    assign inst_invalid_o = invalid_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed + random bench for id_stage_fwd against a cycle-level behavioural model.
module tb_id_stage_fwd;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_ready;
    logic [31:0] pc_i, inst_i;
    logic        rf_re1, rf_re2;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_wreg, ex_is_load, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic        out_valid, wreg_o, inst_invalid_o;
    logic [31:0] pc_o, reg1_o, reg2_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [4:0]  wd_o;

    logic [31:0] regs [32];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    id_stage_fwd dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .inst_invalid_o(inst_invalid_o)
    );

    typedef struct {
        bit          re1, re2, wreg, inv;
        bit   [4:0]  rs, rt, wd;
        bit   [31:0] imm1, imm2;
        bit   [7:0]  aluop;
        bit   [2:0]  alusel;
    } dec_t;

    // expected ID/EX register contents
    bit        m_valid, m_wreg, m_inv;
    bit [31:0] m_pc, m_reg1, m_reg2;
    bit [7:0]  m_aluop;
    bit [2:0]  m_alusel;
    bit [4:0]  m_wd;

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        bit [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        d = '{default: 0};
        d.inv = 1;
        d.rs = ins[25:21];
        d.rt = ins[20:16];
        if (op == 6'h0D || op == 6'h0C || op == 6'h0E) begin
            d.re1 = 1; d.imm2 = {16'h0, ins[15:0]}; d.wd = ins[20:16];
            d.wreg = 1; d.alusel = 3'd1; d.inv = 0;
            d.aluop = (op == 6'h0D) ? 8'h25 : (op == 6'h0C) ? 8'h24 : 8'h26;
        end else if (op == 6'h0F) begin
            d.imm2 = {ins[15:0], 16'h0}; d.wd = ins[20:16];
            d.wreg = 1; d.aluop = 8'h25; d.alusel = 3'd1; d.inv = 0;
        end else if (op == 6'h00) begin
            case (fn)
                6'h24: begin d.aluop = 8'h24; d.alusel = 3'd1; d.inv = 0; end
                6'h25: begin d.aluop = 8'h25; d.alusel = 3'd1; d.inv = 0; end
                6'h26: begin d.aluop = 8'h26; d.alusel = 3'd1; d.inv = 0; end
                6'h27: begin d.aluop = 8'h27; d.alusel = 3'd1; d.inv = 0; end
                6'h21: begin d.aluop = 8'h21; d.alusel = 3'd4; d.inv = 0; end
                6'h23: begin d.aluop = 8'h23; d.alusel = 3'd4; d.inv = 0; end
                6'h00: begin d.aluop = 8'h7C; d.alusel = 3'd2; d.inv = 0; end
                6'h02: begin d.aluop = 8'h02; d.alusel = 3'd2; d.inv = 0; end
                6'h03: begin d.aluop = 8'h03; d.alusel = 3'd2; d.inv = 0; end
                default: ;
            endcase
            if (!d.inv) begin
                d.re2 = 1; d.wd = ins[15:11]; d.wreg = 1;
                if (d.alusel == 3'd2) d.imm1 = {27'h0, ins[10:6]};
                else d.re1 = 1;
            end
        end
        return d;
    endfunction

    function automatic bit [31:0] ref_opnd(input bit re, input bit [4:0] a, input bit [31:0] imm);
        if (!re) return imm;
        if (a == 0) return 0;
        if (ex_wreg && ex_wd == a) return ex_wdata;
        if (mem_wreg && mem_wd == a) return mem_wdata;
        return regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("pc_o", pc_o, m_pc);
            chk("aluop_o", aluop_o, m_aluop);
            chk("alusel_o", alusel_o, m_alusel);
            chk("wreg_o", wreg_o, m_wreg);
            chk("inst_invalid_o", inst_invalid_o, m_inv);
            if (!m_inv) begin
                chk("reg1_o", reg1_o, m_reg1);
                chk("reg2_o", reg2_o, m_reg2);
                chk("wd_o", wd_o, m_wd);
            end
        end
    endtask

    // One clock: check combinational outputs mid-cycle, then the register after the edge.
    task automatic tick();
        dec_t d;
        bit adv, stall;
        bit [31:0] o1, o2;
        @(negedge clk);
        d = ref_decode(inst_i);
        adv = out_ready || !m_valid;
        stall = ex_is_load && ex_wreg && ex_wd != 0 &&
                ((d.re1 && ex_wd == d.rs) || (d.re2 && ex_wd == d.rt));
        chk("in_ready", in_ready, flush || (adv && !stall));
        chk("rf_re1", rf_re1, d.re1);
        chk("rf_re2", rf_re2, d.re2);
        o1 = ref_opnd(d.re1, d.rs, d.imm1);
        o2 = ref_opnd(d.re2, d.rt, d.imm2);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_pc = 0; m_aluop = 0; m_alusel = 0;
            m_reg1 = 0; m_reg2 = 0; m_wd = 0; m_wreg = 0; m_inv = 0;
        end else if (flush) m_valid = 0;
        else if (adv && stall) m_valid = 0;
        else if (adv && in_valid) begin
            m_valid = 1; m_pc = pc_i; m_aluop = d.aluop; m_alusel = d.alusel;
            m_reg1 = o1; m_reg2 = o2; m_wd = d.wd; m_wreg = d.wreg; m_inv = d.inv;
        end else if (adv) m_valid = 0;
        check_out();
    endtask

    task automatic check_reset_values();
        chk("rst out_valid", out_valid, 0);
        chk("rst pc_o", pc_o, 0);
        chk("rst aluop_o", aluop_o, 0);
        chk("rst alusel_o", alusel_o, 0);
        chk("rst reg1_o", reg1_o, 0);
        chk("rst reg2_o", reg2_o, 0);
        chk("rst wd_o", wd_o, 0);
        chk("rst wreg_o", wreg_o, 0);
        chk("rst inst_invalid_o", inst_invalid_o, 0);
    endtask

    function automatic logic [31:0] rand_inst();
        bit [4:0] rs, rt, rd;
        bit [5:0] fns [9] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h00, 6'h02, 6'h03};
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: return {6'h0D, rs, rt, 16'($urandom)};
            1: return {6'h0C, rs, rt, 16'($urandom)};
            2: return {6'h0E, rs, rt, 16'($urandom)};
            3: return {6'h0F, 5'd0, rt, 16'($urandom)};
            4, 5: return {6'h00, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 8)]};
            6: return {6'h00, rs, rt, rd, 5'd0, 6'h08};
            default: return {6'h3F, rs, rt, 16'($urandom)};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
        rst = 1; flush = 0; in_valid = 0; out_ready = 1; pc_i = 0; inst_i = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
        tick(); tick();
        check_reset_values();
        rst = 0;

        // ori $1,$0,0x1100
        in_valid = 1; pc_i = 32'h100; inst_i = 32'h34011100;
        tick();
        chk("t1 valid", out_valid, 1);
        chk("t1 reg1", reg1_o, 0);
        chk("t1 reg2", reg2_o, 32'h00001100);
        chk("t1 wd", wd_o, 1);
        chk("t1 aluop", aluop_o, 8'h25);
        chk("t1 alusel", alusel_o, 1);

        // ori $2,$1,0x20: EX beats MEM beats regfile
        pc_i = 32'h104; inst_i = 32'h34220020;
        ex_wreg = 1; ex_wd = 1; ex_wdata = 32'h1234;
        mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h9999;
        tick();
        chk("t2 ex fwd", reg1_o, 32'h1234);
        ex_wreg = 0;
        tick();
        chk("t2 mem fwd", reg1_o, 32'h9999);
        mem_wreg = 0;
        tick();
        chk("t2 rf", reg1_o, regs[1]);

        // or $3,$1,$2 behind a load of $2
        pc_i = 32'h108; inst_i = 32'h00221825;
        ex_is_load = 1; ex_wreg = 1; ex_wd = 2; ex_wdata = 32'hBAD0;
        tick();
        chk("t3 bubble", out_valid, 0);
        ex_is_load = 0; ex_wreg = 0;
        mem_wreg = 1; mem_wd = 2; mem_wdata = 32'h55AA;
        tick();
        chk("t3 issue", out_valid, 1);
        chk("t3 reg2 mem", reg2_o, 32'h55AA);

        // backpressure holds the or bundle; xor $5,$1,$2 waits
        out_ready = 0; pc_i = 32'h10C; inst_i = 32'h00222826;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4 hold reg2", reg2_o, 32'h55AA);
            chk("t4 hold wd", wd_o, 3);
        end
        out_ready = 1;
        tick();
        chk("t4 next wd", wd_o, 5);
        mem_wreg = 0;

        // flush drops input; then sll $4,$0,3 with EX writing $0
        flush = 1; pc_i = 32'h110;
        tick();
        chk("t5 flushed", out_valid, 0);
        flush = 0; inst_i = 32'h000020C0;
        ex_wreg = 1; ex_wd = 0; ex_wdata = 32'hDEAD;
        tick();
        chk("t5 reg2 zero", reg2_o, 0);
        chk("t5 reg1 sa", reg1_o, 3);
        ex_wreg = 0;

        // unsupported opcode, then reset while stalled under backpressure
        pc_i = 32'h114; inst_i = 32'hFC000000;
        tick();
        chk("t6 valid", out_valid, 1);
        chk("t6 invalid", inst_invalid_o, 1);
        chk("t6 wreg", wreg_o, 0);
        out_ready = 0; inst_i = 32'h00221825;
        ex_is_load = 1; ex_wreg = 1; ex_wd = 1;
        tick();
        rst = 1;
        tick();
        check_reset_values();
        rst = 0; ex_is_load = 0; ex_wreg = 0; out_ready = 1;

        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            pc_i       = $urandom;
            inst_i     = rand_inst();
            ex_wreg    = 1'($urandom);
            ex_wd      = 5'($urandom_range(0, 3));
            ex_wdata   = $urandom;
            ex_is_load = ($urandom_range(0, 2) == 0);
            mem_wreg   = 1'($urandom);
            mem_wd     = 5'($urandom_range(0, 3));
            mem_wdata  = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
